// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: routes a camera pixel stream or a full-buffer colour fill into frame-buffer writes
module fb_write_ctrl #(
  parameter int AW   = 15,
  parameter int DW   = 12,
  parameter int NPIX = 19200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          px_valid,
  input  logic [DW-1:0] px_data,
  input  logic          clr_req,
  input  logic [DW-1:0] clr_color,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          busy,
  output logic          frame_done,
  output logic          clr_done,
  output logic          frame_err,
  output logic [7:0]    drop_cnt
);
  typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR} state_t;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, wptr;
  logic          pend_q, pend_d;
  logic [DW-1:0] color_q, color_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          clr_done_q, clr_done_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    drop_q, drop_d;
  logic          cap, clr, cap_wr, cap_last, clr_last;
  assign cap      = state_q == CAPTURE;
  assign clr      = state_q == CLEAR;
  // a restart inside a frame makes the coincident pixel land at address 0
  assign wptr     = (cap && frame_start) ? '0 : ptr_q;
  assign cap_wr   = cap && px_valid;
  assign cap_last = cap_wr && wptr == LAST;
  assign clr_last = clr && ptr_q == LAST;
  // state register
  always_ff @(posedge clk)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // next state: a clear (new or pending) wins over a frame start in IDLE
  always_comb
    state_d = state_q == IDLE    ? ((clr_req || pend_q) ? CLEAR : frame_start ? CAPTURE : IDLE) :
              state_q == CAPTURE ? (cap_last ? IDLE : CAPTURE) :
              state_q == CLEAR   ? (clr_last ? IDLE : CLEAR) : IDLE;
  // datapath and registered-output next values
  always_comb begin
    ptr_d        = cap ? (cap_last ? '0 : cap_wr ? wptr + 1'b1 : wptr) :
                   clr ? (clr_last ? '0 : ptr_q + 1'b1) : '0;
    pend_d       = cap && (pend_q || clr_req);
    color_d      = (!clr && clr_req) ? clr_color : color_q;
    regwrite_d   = cap_wr || clr;
    addr_d       = cap_wr ? wptr : clr ? ptr_q : addr_q;
    data_d       = cap_wr ? px_data : clr ? color_q : data_q;
    busy_d       = state_d != IDLE;
    frame_done_d = cap_last;
    clr_done_d   = clr_last;
    frame_err_d  = cap && frame_start && ptr_q != '0;
    drop_d       = drop_q + 8'(clr && px_valid && drop_q != 8'hff);
  end
  // datapath and output registers
  always_ff @(posedge clk)
    if (!reset) begin
      ptr_q        <= '0;
      pend_q       <= 1'b0;
      color_q      <= '0;
      regwrite_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      clr_done_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      drop_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pend_q       <= pend_d;
      color_q      <= color_d;
      regwrite_q   <= regwrite_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      clr_done_q   <= clr_done_d;
      frame_err_q  <= frame_err_d;
      drop_q       <= drop_d;
    end
  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = regwrite_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign clr_done   = clr_done_q;
  assign frame_err  = frame_err_q;
  assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: directed and random stimulus against a cycle-level reference of the write controller
module tb_fb_write_ctrl;
  localparam int AW = 3, DW = 12, NPIX = 8;
  logic clk = 0, reset = 0, frame_start = 0, px_valid = 0, clr_req = 0;
  logic [DW-1:0] px_data = '0, clr_color = '0;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic regwrite, busy, frame_done, clr_done, frame_err;
  logic [7:0] drop_cnt;
  fb_write_ctrl #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .px_valid(px_valid), .px_data(px_data),
    .clr_req(clr_req), .clr_color(clr_color), .addr_in(addr_in), .data_in(data_in),
    .regwrite(regwrite), .busy(busy), .frame_done(frame_done), .clr_done(clr_done),
    .frame_err(frame_err), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int mode, pos, drops, col, e_addr, e_data;
  bit pend, e_we, e_busy, e_fd, e_cd, e_fe;
  int we_seen, busy_seen, fd_seen, cd_seen, fe_seen;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // mode 0 = idle, 1 = capturing a frame, 2 = filling the buffer
  task automatic model(input bit r, input bit fs, input bit pv, input int pd, input bit cr, input int cc);
    e_we = 0; e_fd = 0; e_cd = 0; e_fe = 0;
    if (!r) begin
      mode = 0; pos = 0; pend = 0; drops = 0; col = 0; e_addr = 0; e_data = 0;
    end else if (mode == 0) begin
      if (cr || pend) begin
        if (cr) col = cc;
        pend = 0; pos = 0; mode = 2;
      end else if (fs) begin
        pos = 0; mode = 1;
      end
    end else if (mode == 1) begin
      if (cr) begin pend = 1; col = cc; end
      if (fs && pos != 0) begin e_fe = 1; pos = 0; end
      if (pv) begin
        e_we = 1; e_addr = pos; e_data = pd; pos++;
        if (pos == NPIX) begin e_fd = 1; mode = 0; pos = 0; end
      end
    end else begin
      e_we = 1; e_addr = pos; e_data = col; pos++;
      if (pv && drops < 255) drops++;
      if (pos == NPIX) begin e_cd = 1; mode = 0; pos = 0; end
    end
    e_busy = mode != 0;
  endtask
  task automatic cyc(input bit r, input bit fs, input bit pv, input int pd, input bit cr, input int cc);
    reset = r; frame_start = fs; px_valid = pv; px_data = DW'(pd); clr_req = cr; clr_color = DW'(cc);
    @(posedge clk);
    model(r, fs, pv, pd & 'hfff, cr, cc & 'hfff);
    #1;
    chk("regwrite", 32'(regwrite), 32'(e_we));
    chk("addr_in", 32'(addr_in), 32'(e_addr));
    chk("data_in", 32'(data_in), 32'(e_data));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("clr_done", 32'(clr_done), 32'(e_cd));
    chk("frame_err", 32'(frame_err), 32'(e_fe));
    chk("drop_cnt", 32'(drop_cnt), 32'(drops));
    we_seen += int'(regwrite); busy_seen += int'(busy);
    fd_seen += int'(frame_done); cd_seen += int'(clr_done); fe_seen += int'(frame_err);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask
  task automatic zero_seen();
    we_seen = 0; busy_seen = 0; fd_seen = 0; cd_seen = 0; fe_seen = 0;
  endtask
  initial begin
    zero_seen();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 1, 7);
    idle(2);
    // single frame of 8 pixels
    zero_seen();
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 1, i, 0, 0);
    idle(2);
    chk("frame_writes", 32'(we_seen), 8);
    chk("frame_done_cnt", 32'(fd_seen), 1);
    // fill from idle
    zero_seen();
    cyc(1, 0, 0, 0, 1, 'hF00);
    idle(10);
    chk("clr_writes", 32'(we_seen), 8);
    chk("clr_done_cnt", 32'(cd_seen), 1);
    chk("clr_busy_cycles", 32'(busy_seen), 8);
    // clear wins over simultaneous frame start; pixels during the fill are dropped
    zero_seen();
    cyc(1, 1, 0, 0, 1, 'h123);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 'h55, 0, 0);
    idle(8);
    chk("drop_after_3", 32'(drop_cnt), 3);
    chk("no_frame_done", 32'(fd_seen), 0);
    // restart mid-frame
    zero_seen();
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 'h10 + i, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 'h20 + i, 0, 0);
    idle(2);
    chk("restart_err_cnt", 32'(fe_seen), 1);
    chk("restart_done_cnt", 32'(fd_seen), 1);
    chk("restart_writes", 32'(we_seen), 11);
    // clear requested mid-capture is deferred until the frame completes
    zero_seen();
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cyc(1, 0, 1, i, 0, 0);
    cyc(1, 0, 1, 4, 1, 'h0F0);
    for (int i = 5; i <= 8; i++) cyc(1, 0, 1, i, 0, 0);
    idle(12);
    chk("deferred_fd", 32'(fd_seen), 1);
    chk("deferred_cd", 32'(cd_seen), 1);
    chk("deferred_writes", 32'(we_seen), 16);
    // reset during the fifth fill write
    cyc(1, 0, 0, 0, 1, 'hABC);
    idle(5);
    chk("fifth_write_addr", 32'(addr_in), 4);
    zero_seen();
    cyc(0, 0, 0, 0, 0, 0);
    idle(10);
    chk("post_reset_writes", 32'(we_seen), 0);
    chk("post_reset_cd", 32'(cd_seen), 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 'h777, 0, 0);
    chk("recapture_addr", 32'(addr_in), 0);
    chk("recapture_data", 32'(data_in), 'h777);
    idle(10);
    // drop counter saturation
    for (int k = 0; k < 35; k++) begin
      cyc(1, 0, 0, 0, 1, k);
      for (int i = 0; i < 9; i++) cyc(1, 0, 1, i, 0, 0);
    end
    chk("drop_saturated", 32'(drop_cnt), 255);
    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 4095)), $urandom_range(0, 39) == 0, int'($urandom_range(0, 4095)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fb_write_ctrl.md
FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 SHALL have parameter AW, default 15, frame-buffer address width in bits.
REQ-002 SHALL have parameter DW, default 12, pixel data width in bits (RGB444).
REQ-003 SHALL have parameter NPIX, default 19200, pixels per frame (160x120); legal range 2 to 2**AW.
REQ-004 SHALL have port clk, input, 1, single clock for all logic; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL have port frame_start, input, 1, one-cycle pulse marking the start of a camera frame.
REQ-007 SHALL have port px_valid, input, 1, px_data is valid this cycle; this is a non-stallable stream.
REQ-008 SHALL have port px_data, input, DW, pixel value.
REQ-009 SHALL have port clr_req, input, 1, one-cycle pulse requesting a full-buffer fill.
REQ-010 SHALL have port clr_color, input, DW, fill value, sampled in the cycle clr_req is accepted.
REQ-011 SHALL have port addr_in, output, AW, frame-buffer write address.
REQ-012 SHALL have port data_in, output, DW, frame-buffer write data.
REQ-013 SHALL have port regwrite, output, 1, frame-buffer write enable.
REQ-014 SHALL have port busy, output, 1, high while in the CAPTURE or CLEAR state.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse after the last pixel of a frame is written.
REQ-016 SHALL have port clr_done, output, 1, one-cycle pulse after the last fill write.
REQ-017 SHALL have port frame_err, output, 1, one-cycle pulse when a frame is restarted before it completes.
REQ-018 SHALL have port drop_cnt, output, 8, saturating count of px_valid cycles that were not written.

Function
REQ-019 SHALL implement the FSM states IDLE, CAPTURE and CLEAR, with a write pointer ptr of AW bits.
REQ-020 SHALL register all outputs; a write accepted in cycle N appears on regwrite/addr_in/data_in in cycle N+1 for exactly one cycle.
REQ-021 In IDLE, clr_req (or a pending clear) SHALL move the FSM to CLEAR, latch clr_color and set ptr=0; this has priority over a simultaneous frame_start.
REQ-022 In IDLE, frame_start without clr_req SHALL move the FSM to CAPTURE with ptr=0.
REQ-023 In IDLE, px_valid SHALL be ignored and SHALL NOT increment drop_cnt, because no frame is open.
REQ-024 In CAPTURE, each px_valid cycle SHALL write px_data at address ptr and then increment ptr.
REQ-025 When the write at ptr=NPIX-1 is accepted in CAPTURE, the FSM SHALL return to IDLE and pulse frame_done in the same cycle as that write's regwrite.
REQ-026 frame_start in CAPTURE with ptr!=0 SHALL reset ptr to 0, stay in CAPTURE and pulse frame_err.
REQ-027 If px_valid coincides with frame_start in CAPTURE, that pixel SHALL be written at address 0 and ptr SHALL become 1.
REQ-028 clr_req in CAPTURE SHALL set a one-deep pending flag; the clear SHALL start in the cycle after frame_done.
REQ-029 A second clr_req while the flag is set SHALL update the latched color only.
REQ-030 In CLEAR, the block SHALL write the latched color at ptr=0..NPIX-1 on consecutive cycles (NPIX writes, no gaps).
REQ-031 At the end of CLEAR, the FSM SHALL pulse clr_done alongside the final write and return to IDLE.
REQ-032 In CLEAR, px_valid SHALL increment drop_cnt (saturating at 255); frame_start SHALL be ignored, not queued.
REQ-033 clr_req during CLEAR SHALL be ignored.
REQ-034 ptr SHALL never exceed NPIX-1, and addr_in SHALL always be less than NPIX when regwrite=1.
REQ-035 busy SHALL deassert in the same cycle as the frame_done/clr_done pulse.

Reset
REQ-036 reset=0 at a rising edge SHALL force IDLE and clear the following to 0: ptr, the pending-clear flag, regwrite, addr_in, data_in, busy, frame_done, clr_done, frame_err and drop_cnt.
REQ-037 Reset mid-CAPTURE or mid-CLEAR SHALL abort the operation with no further writes and no done pulse; writes already issued are not undone.

Verification
REQ-038 NPIX=8, frame_start then 8 px_valid with data 0x001..0x008 -> addresses 0..7 written in order with 1-cycle latency, frame_done once, then IDLE.
REQ-039 NPIX=8, clr_req with clr_color=0xF00 in IDLE -> 8 consecutive writes of 0xF00 to addresses 0..7, clr_done with the 8th write, busy high for 8 cycles.
REQ-040 NPIX=8, clr_req and frame_start in the same IDLE cycle -> CLEAR runs, frame_start is dropped, and px_valid during CLEAR (3 cycles) gives drop_cnt=3.
REQ-041 NPIX=8, frame_start, 3 pixels, frame_start again, 8 pixels -> frame_err pulse once, addresses 0,1,2,0..7 written, one frame_done.
REQ-042 NPIX=8, clr_req (0x0F0) at pixel 4 of a capture -> capture completes (frame_done), then the clear starts the next cycle with 0x0F0.
REQ-043 Reset asserted during the 5th clear write -> no regwrite after reset, no clr_done, all outputs 0, and a new frame_start captures from address 0.
